// File: rtl/dbg_apb_pkg.sv
// Shared types and helpers for the debug APB master sequencer/arbiter.
package dbg_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_e;

  localparam int DEF_ADDR_WIDTH  = 5;
  localparam int DEF_WDATA_WIDTH = 32;
  localparam int DEF_RDATA_WIDTH = 32;

  // Index width for a set of n items; a single item still needs one bit.
  function automatic int slv_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dbg_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i,
// wrapping modulo NR_REQ. The pointer register lives in the parent.
module dbg_rr_arbiter
  import dbg_apb_pkg::*;
#(
  parameter int NR_REQ = 2
) (
  input  logic [NR_REQ-1:0]         req_i,
  input  logic [slv_w(NR_REQ)-1:0]  ptr_i,
  input  logic                      en_i,
  output logic [NR_REQ-1:0]         grant_o,
  output logic [slv_w(NR_REQ)-1:0]  idx_o
);

  localparam int PW = slv_w(NR_REQ);

  logic found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    for (int k = 0; k < NR_REQ; k++) begin
      int c;
      c = int'(ptr_i) + k;
      if (c >= NR_REQ) c = c - NR_REQ;
      if (en_i && !found && req_i[c]) begin
        found      = 1'b1;
        grant_o[c] = 1'b1;
        idx_o      = PW'(c);
      end
    end
  end

endmodule

// File: rtl/dbg_apb_master_arb.sv
// APB master sequencer with round-robin arbitration for the debug APB bus.
// Optional ACCESS-phase timeout is enabled by defining DBG_APB_TIMEOUT_EN.
module dbg_apb_master_arb
  import dbg_apb_pkg::*;
#(
  parameter int NR_REQ         = 2,
  parameter int NR_SLAVES      = 1,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int WDATA_WIDTH    = DEF_WDATA_WIDTH,
  parameter int RDATA_WIDTH    = DEF_RDATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NR_REQ-1:0]                        req_valid,
  output logic [NR_REQ-1:0]                        req_ready,
  input  logic [NR_REQ-1:0][slv_w(NR_SLAVES)-1:0]  req_slave,
  input  logic [NR_REQ-1:0][ADDR_WIDTH-1:0]        req_addr,
  input  logic [NR_REQ-1:0]                        req_wr_rd,
  input  logic [NR_REQ-1:0][WDATA_WIDTH-1:0]       req_wdata,
  output logic [NR_REQ-1:0]                        rsp_valid,
  output logic                                     rsp_err,
  output logic [RDATA_WIDTH-1:0]                   rsp_rdata,
  output logic [ADDR_WIDTH-1:0]                    apb_addr,
  output logic [NR_SLAVES-1:0]                     apb_sel,
  output logic                                     apb_enable,
  output logic                                     apb_wr_rd,
  output logic [WDATA_WIDTH-1:0]                   apb_wdata,
  input  logic                                     apb_ready,
  input  logic [RDATA_WIDTH-1:0]                   apb_rdata
);

  localparam int PW = slv_w(NR_REQ);

  if (NR_REQ < 1 || NR_REQ > 8 || NR_SLAVES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("dbg_apb_master_arb: unsupported parameter set");
  end

  state_e                  state_q, state_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [PW-1:0]           owner_q, owner_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    wr_q, wr_d;
  logic [WDATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [NR_SLAVES-1:0]    sel_q, sel_d;
  logic                    en_q, en_d;
  logic [NR_REQ-1:0]       rsp_valid_q, rsp_valid_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [RDATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;

  logic [NR_REQ-1:0]       grant;
  logic [PW-1:0]           gidx;

`ifdef DBG_APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]           to_cnt_q, to_cnt_d;
`endif

  dbg_rr_arbiter #(.NR_REQ(NR_REQ)) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .en_i    (state_q == ST_IDLE),
    .grant_o (grant),
    .idx_o   (gidx)
  );

  assign req_ready = grant;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    en_d        = en_q;
    rsp_valid_d = '0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
`ifdef DBG_APB_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          owner_d = gidx;
          ptr_d   = (int'(gidx) == NR_REQ - 1) ? '0 : gidx + PW'(1);
          addr_d  = req_addr[gidx];
          wr_d    = req_wr_rd[gidx];
          wdata_d = req_wdata[gidx];
          // Out-of-range target: skip the bus entirely and answer with an error.
          if (int'(req_slave[gidx]) >= NR_SLAVES) begin
            state_d = ST_RESP;
            for (int r = 0; r < NR_REQ; r++) rsp_valid_d[r] = (r == int'(gidx));
            rsp_err_d = 1'b1;
          end else begin
            state_d = ST_SETUP;
            for (int s = 0; s < NR_SLAVES; s++) sel_d[s] = (s == int'(req_slave[gidx]));
          end
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        en_d    = 1'b1;
`ifdef DBG_APB_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end
      ST_ACCESS: begin
        if (apb_ready) begin
          state_d = ST_RESP;
          sel_d   = '0;
          en_d    = 1'b0;
          for (int r = 0; r < NR_REQ; r++) rsp_valid_d[r] = (r == int'(owner_q));
          rsp_rdata_d = wr_q ? '0 : apb_rdata;
        end
`ifdef DBG_APB_TIMEOUT_EN
        else if (to_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          // This wait cycle brings the count to the limit: abandon the access.
          state_d = ST_RESP;
          sel_d   = '0;
          en_d    = 1'b0;
          for (int r = 0; r < NR_REQ; r++) rsp_valid_d[r] = (r == int'(owner_q));
          rsp_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + CW'(1);
        end
`endif
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      sel_q       <= '0;
      en_q        <= 1'b0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef DBG_APB_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      en_q        <= en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef DBG_APB_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  assign apb_addr   = addr_q;
  assign apb_sel    = sel_q;
  assign apb_enable = en_q;
  assign apb_wr_rd  = wr_q;
  assign apb_wdata  = wdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_rdata  = rsp_rdata_q;

endmodule

// File: tb/tb_dbg_apb_master_arb.sv
// Bench for dbg_apb_master_arb: directed scenarios plus randomized traffic
// against a transaction-level model checked every cycle.
module tb_dbg_apb_master_arb;

  localparam int NR_REQ = 3;
  localparam int NS     = 3;
  localparam int SW     = 2;
  localparam int AW     = 5;
  localparam int WW     = 32;
  localparam int RW     = 32;
  localparam int TO     = 8;

  logic                          clk = 1'b0;
  logic                          rst;
  logic [NR_REQ-1:0]             req_valid;
  logic [NR_REQ-1:0]             req_ready;
  logic [NR_REQ-1:0][SW-1:0]     req_slave;
  logic [NR_REQ-1:0][AW-1:0]     req_addr;
  logic [NR_REQ-1:0]             req_wr_rd;
  logic [NR_REQ-1:0][WW-1:0]     req_wdata;
  logic [NR_REQ-1:0]             rsp_valid;
  logic                          rsp_err;
  logic [RW-1:0]                 rsp_rdata;
  logic [AW-1:0]                 apb_addr;
  logic [NS-1:0]                 apb_sel;
  logic                          apb_enable;
  logic                          apb_wr_rd;
  logic [WW-1:0]                 apb_wdata;
  logic                          apb_ready;
  logic [RW-1:0]                 apb_rdata;

  dbg_apb_master_arb #(
    .NR_REQ(NR_REQ), .NR_SLAVES(NS), .ADDR_WIDTH(AW), .WDATA_WIDTH(WW),
    .RDATA_WIDTH(RW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_slave(req_slave),
    .req_addr(req_addr), .req_wr_rd(req_wr_rd), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .apb_addr(apb_addr), .apb_sel(apb_sel), .apb_enable(apb_enable),
    .apb_wr_rd(apb_wr_rd), .apb_wdata(apb_wdata),
    .apb_ready(apb_ready), .apb_rdata(apb_rdata)
  );

  always #5 clk = ~clk;

  // Slave read data is a recognisable function of the address on the bus.
  assign apb_rdata = {16'hCAFE, 11'd0, apb_addr};

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [NR_REQ-1:0] v, input int p);
    for (int k = 0; k < NR_REQ; k++) begin
      int c;
      c = (p + k) % NR_REQ;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Transaction model: one transfer in flight, described by its age since accept.
  bit           m_live = 0, m_busy = 0, m_resp = 0, m_err = 0, m_zero = 1, m_wr = 0;
  int           m_ptr = 0, m_owner = 0, m_slave = 0, m_age = 0, m_wait = 0;
  logic [AW-1:0] m_addr = '0;
  logic [WW-1:0] m_wdata = '0;
  logic [RW-1:0] m_rdata = '0;

  always @(negedge clk) begin : compare
    logic [NR_REQ-1:0] e_rdy, e_rv;
    logic [NS-1:0]     e_sel;
    logic              e_en, e_err;
    logic [RW-1:0]     e_rd;
    int                g;
    g = m_busy ? -1 : pick(req_valid, m_ptr);
    if (m_live) begin
      e_rdy = '0; e_rv = '0; e_sel = '0; e_en = 1'b0; e_err = 1'b0; e_rd = '0;
      if (g >= 0) e_rdy[g] = 1'b1;
      if (m_busy && m_resp) begin
        e_rv[m_owner] = 1'b1; e_err = m_err; e_rd = m_rdata;
      end else if (m_busy) begin
        e_sel[m_slave] = 1'b1; e_en = (m_age == 2);
      end
      chk("req_ready", req_ready, e_rdy);
      chk("apb_sel", apb_sel, e_sel);
      chk("apb_enable", apb_enable, e_en);
      chk("rsp_valid", rsp_valid, e_rv);
      chk("rsp_err", rsp_err, e_err);
      chk("rsp_rdata", rsp_rdata, e_rd);
      if (m_zero) begin
        chk("apb_addr_rst", apb_addr, 0);
        chk("apb_wdata_rst", apb_wdata, 0);
        chk("apb_wr_rst", apb_wr_rd, 0);
      end else if (e_sel != 0) begin
        chk("apb_addr", apb_addr, m_addr);
        chk("apb_wdata", apb_wdata, m_wdata);
        chk("apb_wr_rd", apb_wr_rd, m_wr);
      end
    end
    // Advance to what the next edge must produce.
    if (rst) begin
      m_live = 1; m_busy = 0; m_ptr = 0; m_zero = 1;
    end else if (!m_busy) begin
      if (g >= 0) begin
        m_busy = 1; m_owner = g; m_slave = int'(req_slave[g]); m_zero = 0;
        m_addr = req_addr[g]; m_wr = req_wr_rd[g]; m_wdata = req_wdata[g];
        m_ptr = (g + 1) % NR_REQ;
        if (m_slave >= NS) begin
          m_resp = 1; m_err = 1; m_rdata = '0;
        end else begin
          m_resp = 0; m_age = 1;
        end
      end
    end else if (m_resp) begin
      m_busy = 0;
    end else if (m_age == 1) begin
      m_age = 2; m_wait = 0;
    end else if (apb_ready) begin
      m_resp = 1; m_err = 0;
      m_rdata = m_wr ? '0 : {16'hCAFE, 11'd0, m_addr};
    end else begin
      m_wait++;
`ifdef DBG_APB_TIMEOUT_EN
      if (m_wait >= TO) begin
        m_resp = 1; m_err = 1; m_rdata = '0;
      end
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input int i, input int s, input logic [AW-1:0] a, input bit w,
                       input logic [WW-1:0] d, output int acc_c);
    int n;
    n = 0;
    req_slave[i] = SW'(s); req_addr[i] = a; req_wr_rd[i] = w; req_wdata[i] = d;
    req_valid[i] = 1'b1;
    #1;
    while (!req_ready[i] && n < 60) begin
      tick(); #1; n++;
    end
    chk("accept_bound", req_ready[i], 1'b1);
    acc_c = cyc;
    tick();
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int i, output int rc);
    int n;
    n = 0;
    while (!rsp_valid[i] && n < 200) begin
      tick(); n++;
    end
    chk("rsp_bound", rsp_valid[i], 1'b1);
    rc = cyc;
  endtask

  task automatic wait_en(output bit ok);
    int n;
    n = 0;
    while (!apb_enable && n < 20) begin
      tick(); n++;
    end
    ok = apb_enable;
    chk("enable_bound", apb_enable, 1'b1);
  endtask

  initial begin : watchdog
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin : stim
    int ac, rc, cnt;
    bit ok;
    int own[$];
    int oc[$];
    rst = 1'b1; req_valid = '0; req_slave = '0; req_addr = '0; req_wr_rd = '0;
    req_wdata = '0; apb_ready = 1'b0;
    tick(); tick();
    chk("reset_sel", apb_sel, 0);
    chk("reset_enable", apb_enable, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rdata", rsp_rdata, 0);
    rst = 1'b0;

    // Single read, zero wait states.
    apb_ready = 1'b1;
    issue(0, 0, 5'h04, 1'b0, 32'h0, ac);
    wait_rsp(0, rc);
    chk("read_latency", rc - ac, 3);
    chk("read_rdata", rsp_rdata, 32'hCAFE_0004);
    chk("read_err", rsp_err, 0);
    tick();

    // Write with three wait states.
    apb_ready = 1'b0;
    issue(1, 1, 5'h10, 1'b1, 32'h1234_5678, ac);
    wait_en(ok);
    cnt = 0;
    while (apb_enable && cnt < 20) begin
      cnt++;
      chk("wr_addr_stable", apb_addr, 5'h10);
      chk("wr_wdata_stable", apb_wdata, 32'h1234_5678);
      chk("wr_sel_stable", apb_sel, 3'b010);
      apb_ready = (cnt == 4);
      tick();
    end
    chk("wr_access_len", cnt, 4);
    chk("wr_rsp_valid", rsp_valid, 3'b010);
    chk("wr_rsp_rdata", rsp_rdata, 0);
    apb_ready = 1'b0;
    tick();

    // Contention from reset: two requesters held valid.
    rst = 1'b1;
    req_slave[0] = 2'd0; req_addr[0] = 5'h01; req_wr_rd[0] = 1'b0;
    req_slave[1] = 2'd1; req_addr[1] = 5'h02; req_wr_rd[1] = 1'b0;
    req_valid = 3'b011; apb_ready = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 17; k++) begin
      for (int i = 0; i < NR_REQ; i++)
        if (req_valid[i] && req_ready[i]) begin
          own.push_back(i); oc.push_back(cyc);
        end
      tick(); #1;
    end
    req_valid = '0;
    chk("contention_count", own.size(), 5);
    if (own.size() >= 4) begin
      chk("grant0", own[0], 0);
      chk("grant1", own[1], 1);
      chk("grant2", own[2], 0);
      chk("grant3", own[3], 1);
      chk("grant_gap", oc[3] - oc[2], 4);
      chk("grant_gap1", oc[1] - oc[0], 4);
    end
    tick(); tick(); tick(); tick(); tick();

    // Out-of-range slave index.
    issue(0, 3, 5'h07, 1'b0, 32'h0, ac);
    chk("oor_sel", apb_sel, 0);
    wait_rsp(0, rc);
    chk("oor_latency", rc - ac, 1);
    chk("oor_err", rsp_err, 1);
    chk("oor_rdata", rsp_rdata, 0);
    tick();

    // Slave never ready.
    apb_ready = 1'b0;
    issue(2, 2, 5'h1F, 1'b0, 32'h0, ac);
    wait_en(ok);
    cnt = 0;
    while (apb_enable && cnt < 120) begin
      cnt++; tick();
    end
`ifdef DBG_APB_TIMEOUT_EN
    chk("timeout_len", cnt, TO);
    chk("timeout_rsp", rsp_valid, 3'b100);
    chk("timeout_err", rsp_err, 1);
`else
    chk("no_timeout_len", cnt >= 100, 1);
    apb_ready = 1'b1;
    wait_rsp(2, rc);
    chk("late_ready_err", rsp_err, 0);
    chk("late_ready_rdata", rsp_rdata, 32'hCAFE_001F);
    apb_ready = 1'b0;
`endif
    tick(); tick();

    // Reset in the middle of a waited access; pointer must restart at 0.
    issue(1, 0, 5'h0A, 1'b1, 32'hDEAD_BEEF, ac);
    wait_en(ok);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_sel", apb_sel, 0);
    chk("rst_mid_en", apb_enable, 0);
    chk("rst_mid_rsp", rsp_valid, 0);
    req_slave[1] = 2'd1; req_addr[1] = 5'h03; req_wr_rd[1] = 1'b0;
    req_slave[2] = 2'd2; req_addr[2] = 5'h05; req_wr_rd[2] = 1'b0;
    req_valid = 3'b110; apb_ready = 1'b1;
    #1;
    chk("rst_ptr_grant", req_ready, 3'b010);
    tick();
    req_valid[1] = 1'b0;
    issue(2, 2, 5'h05, 1'b0, 32'h0, ac);
    wait_rsp(2, rc);
    chk("post_rst_rdata", rsp_rdata, 32'hCAFE_0005);
    tick();

    // Randomized traffic, wait states, out-of-range targets and stray resets.
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < NR_REQ; i++) begin
        if ($urandom_range(0, 3) != 0) begin
          req_valid[i] = ($urandom_range(0, 1) == 1);
          req_slave[i] = SW'($urandom_range(0, 3));
          req_addr[i]  = AW'($urandom);
          req_wr_rd[i] = ($urandom_range(0, 1) == 1);
          req_wdata[i] = $urandom;
        end
      end
      apb_ready = ($urandom_range(0, 9) < 6);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; req_valid = '0; apb_ready = 1'b1;
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
